// File: rtl/avalon_st_gen_pkg.sv
// Shared definitions for the Avalon-ST packet generator: LFSR taps, FSM states
// and the single-step LFSR function that is also used to build expected payloads.
package avalon_st_gen_pkg;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Galois, shift-right form of x^32+x^22+x^2+x+1.
   function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
      return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with advance and load enables; a zero load value is
// replaced by SEED so the register can never lock up at zero.
module lfsr32
   import avalon_st_gen_pkg::*;
#(
   parameter logic [31:0] SEED      = 32'hACE1_2345,
   parameter int          OUT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 adv,
   input  logic                 load,
   input  logic [31:0]          load_val,
   output logic [OUT_WIDTH-1:0] data
);

   logic [31:0] state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SEED;
      end else if (load) begin
         state_q <= (load_val == 32'h0) ? SEED : load_val;
      end else if (adv) begin
         state_q <= lfsr_next(state_q);
      end
   end

   assign data = state_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/avalon_st_packet_gen.sv
// Avalon-ST packet source: emits pkt_len beats of LFSR payload per accepted start,
// with back-to-back restart on the eop transfer and status pulses for done/len_err.
module avalon_st_packet_gen
   import avalon_st_gen_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          LEN_WIDTH  = 16,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic                  seed_load,
   input  logic [31:0]           seed,
   output logic                  busy,
   output logic                  done,
   output logic                  len_err,
   output logic [31:0]           pkt_count,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_startofpacket,
   output logic                  out_endofpacket,
   input  logic                  out_ready,
   output state_t                dbg_state
);

   state_t                state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, beat_q;
   logic [DATA_WIDTH-1:0] lfsr_data;
   logic                  xfer, len_load, done_d, len_err_d, seed_ld;

   // Handshake: a beat transfers on any cycle with out_valid && out_ready
   // (readyLatency 0); valid, data, sop and eop are held while the sink stalls.
   always_comb begin
      busy              = (state_q == SEND);
      out_valid         = busy;
      out_data          = busy ? lfsr_data : '0;
      out_startofpacket = busy && (beat_q == '0);
      out_endofpacket   = busy && (beat_q == len_q - LEN_WIDTH'(1));
      xfer              = out_valid && out_ready;
      seed_ld           = seed_load && (state_q == IDLE);
      dbg_state         = state_q;
   end

   always_comb begin
      state_d   = state_q;
      len_load  = 1'b0;
      done_d    = 1'b0;
      len_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (pkt_len != '0) begin
                  state_d  = SEND;
                  len_load = 1'b1;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         SEND: begin
            // start is only honoured on the eop transfer; elsewhere it is dropped.
            if (xfer && out_endofpacket) begin
               done_d = 1'b1;
               if (start && (pkt_len != '0)) begin
                  len_load = 1'b1;
               end else begin
                  state_d   = IDLE;
                  len_err_d = start;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         len_q     <= '0;
         beat_q    <= '0;
         done      <= 1'b0;
         len_err   <= 1'b0;
         pkt_count <= '0;
      end else begin
         state_q <= state_d;
         done    <= done_d;
         len_err <= len_err_d;
         if (done_d) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (len_load) begin
            len_q  <= pkt_len;
            beat_q <= '0;
         end else if (xfer) begin
            beat_q <= beat_q + LEN_WIDTH'(1);
         end
      end
   end

   lfsr32 #(
      .SEED      (LFSR_SEED),
      .OUT_WIDTH (DATA_WIDTH)
   ) u_lfsr (
      .clk      (clk),
      .reset_n  (reset_n),
      .adv      (xfer),
      .load     (seed_ld),
      .load_val (seed),
      .data     (lfsr_data)
   );

endmodule

// File: tb/tb_avalon_st_packet_gen.sv
// Directed bench for avalon_st_packet_gen: inputs driven on the falling edge,
// outputs sampled 1 ns later; expected payload rebuilt with lfsr_next.
module tb_avalon_st_packet_gen;
   import avalon_st_gen_pkg::*;

   localparam int DW = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] pkt_len = '0;
   logic          seed_load = 1'b0;
   logic [31:0]   seed = '0;
   logic          out_ready = 1'b1;
   logic          busy, done, len_err;
   logic [31:0]   pkt_count;
   logic          out_valid, out_startofpacket, out_endofpacket;
   logic [DW-1:0] out_data;
   state_t        dbg_state;

   int          checks = 0;
   int          failures = 0;
   int          exp_count = 0;
   logic [31:0] model = 32'hACE1_2345;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   avalon_st_packet_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .LFSR_SEED(32'hACE1_2345)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .pkt_len           (pkt_len),
      .seed_load         (seed_load),
      .seed              (seed),
      .busy              (busy),
      .done              (done),
      .len_err           (len_err),
      .pkt_count         (pkt_count),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_ready         (out_ready),
      .dbg_state         (dbg_state)
   );

   task automatic test_reset();
      @(negedge clk); #1;
      checks++;
      if ({busy, done, len_err, out_valid, out_startofpacket, out_endofpacket} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags act=%b exp=000000",
                  {busy, done, len_err, out_valid, out_startofpacket, out_endofpacket});
      end
      checks++;
      if (pkt_count !== 32'd0) begin
         failures++; $display("FAIL reset_count act=%0d exp=0", pkt_count);
      end
      checks++;
      if (out_data !== 8'h00) begin
         failures++; $display("FAIL reset_data act=%h exp=00", out_data);
      end
      checks++;
      if (dbg_state !== IDLE) begin
         failures++; $display("FAIL reset_state act=%0d exp=%0d", dbg_state, IDLE);
      end
      @(negedge clk);
      reset_n = 1'b1;
      model = 32'hACE1_2345;
      exp_count = 0;
   endtask

   task automatic test_basic();
      logic [7:0] exp_b[4];
      exp_b = '{8'h01, 8'h03, 8'h02, 8'h01};
      @(negedge clk);
      seed_load = 1'b1; seed = 32'h1;
      @(negedge clk);
      seed_load = 1'b0; start = 1'b1; pkt_len = 16'd4;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL basic_idle_valid act=%b exp=0", out_valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         checks++;
         if ({out_valid, busy, out_data} !== {1'b1, 1'b1, exp_b[i]}) begin
            failures++;
            $display("FAIL basic_beat%0d act=v%b b%b d%h exp=v1 b1 d%h", i, out_valid, busy, out_data, exp_b[i]);
         end
         checks++;
         if ({out_startofpacket, out_endofpacket} !== {i == 0, i == 3}) begin
            failures++;
            $display("FAIL basic_sopeop%0d act=%b%b exp=%b%b", i, out_startofpacket, out_endofpacket, i == 0, i == 3);
         end
      end
      @(negedge clk); #1;
      exp_count = 1;
      checks++;
      if ({done, out_valid, busy} !== 3'b100 || pkt_count !== 32'd1) begin
         failures++;
         $display("FAIL basic_done act=d%b v%b b%b cnt%0d exp=d1 v0 b0 cnt1", done, out_valid, busy, pkt_count);
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL basic_done_pulse act=%b exp=0", done);
      end
      model = 32'h1;
      for (int i = 0; i < 4; i++) model = lfsr_next(model);
   endtask

   task automatic test_single();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b1; pkt_len = 16'd1;
         @(negedge clk);
         start = 1'b0;
         #1;
         checks++;
         if ({out_valid, out_startofpacket, out_endofpacket} !== 3'b111) begin
            failures++;
            $display("FAIL single%0d_flags act=%b%b%b exp=111", k, out_valid, out_startofpacket, out_endofpacket);
         end
         checks++;
         if (out_data !== model[7:0]) begin
            failures++; $display("FAIL single%0d_data act=%h exp=%h", k, out_data, model[7:0]);
         end
         model = lfsr_next(model);
         @(negedge clk); #1;
         exp_count++;
         checks++;
         if ({done, out_valid} !== 2'b10 || pkt_count !== exp_count) begin
            failures++;
            $display("FAIL single%0d_done act=d%b v%b cnt%0d exp=d1 v0 cnt%0d", k, done, out_valid, pkt_count, exp_count);
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0]   m;
      logic [DW-1:0] prev_data;
      logic          prev_sop, prev_eop, stalled;
      int            beat, cyc;
      m = 32'h1234_5678;
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back(m[7:0]);
         m = lfsr_next(m);
      end
      @(negedge clk);
      seed_load = 1'b1; seed = 32'h1234_5678; start = 1'b1; pkt_len = 16'd20;
      beat = 0; cyc = 0; stalled = 1'b0;
      prev_data = '0; prev_sop = 1'b0; prev_eop = 1'b0;
      while (beat < 20 && cyc < 200) begin
         @(negedge clk);
         seed_load = 1'b0; start = 1'b0;
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         #1;
         checks++;
         if (out_valid !== 1'b1 || dbg_state !== SEND) begin
            failures++; $display("FAIL stall_valid beat%0d act=%b exp=1", beat, out_valid);
         end
         if (stalled) begin
            checks++;
            if ({out_data, out_startofpacket, out_endofpacket} !== {prev_data, prev_sop, prev_eop}) begin
               failures++;
               $display("FAIL stall_hold beat%0d act=%h%b%b exp=%h%b%b", beat, out_data,
                        out_startofpacket, out_endofpacket, prev_data, prev_sop, prev_eop);
            end
         end
         checks++;
         if (out_data !== exp_q[0]) begin
            failures++; $display("FAIL stall_data beat%0d act=%h exp=%h", beat, out_data, exp_q[0]);
         end
         checks++;
         if ({out_startofpacket, out_endofpacket} !== {beat == 0, beat == 19}) begin
            failures++;
            $display("FAIL stall_sopeop beat%0d act=%b%b exp=%b%b", beat, out_startofpacket,
                     out_endofpacket, beat == 0, beat == 19);
         end
         prev_data = out_data; prev_sop = out_startofpacket; prev_eop = out_endofpacket;
         stalled = !out_ready;
         if (out_ready) begin
            void'(exp_q.pop_front());
            beat++;
         end
         cyc++;
      end
      checks++;
      if (beat != 20) begin
         failures++; $display("FAIL stall_beats act=%0d exp=20", beat);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      exp_count++;
      checks++;
      if ({done, out_valid} !== 2'b10 || pkt_count !== exp_count) begin
         failures++;
         $display("FAIL stall_done act=d%b v%b cnt%0d exp=d1 v0 cnt%0d", done, out_valid, pkt_count, exp_count);
      end
      exp_q.delete();
      model = m;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      start = 1'b1; pkt_len = 16'd5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start   = (i == 4);
         pkt_len = (i == 4) ? 16'd3 : 16'd5;
         #1;
         checks++;
         if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, model[7:0], i == 0, i == 4}) begin
            failures++;
            $display("FAIL b2b_a%0d act=v%b d%h s%b e%b exp=v1 d%h s%b e%b", i, out_valid, out_data,
                     out_startofpacket, out_endofpacket, model[7:0], i == 0, i == 4);
         end
         model = lfsr_next(model);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (i == 0) begin
            checks++;
            if ({done, busy} !== 2'b11) begin
               failures++; $display("FAIL b2b_gap act=d%b b%b exp=d1 b1", done, busy);
            end
         end
         checks++;
         if ({out_valid, out_data, out_startofpacket, out_endofpacket} !== {1'b1, model[7:0], i == 0, i == 2}) begin
            failures++;
            $display("FAIL b2b_b%0d act=v%b d%h s%b e%b exp=v1 d%h s%b e%b", i, out_valid, out_data,
                     out_startofpacket, out_endofpacket, model[7:0], i == 0, i == 2);
         end
         model = lfsr_next(model);
      end
      @(negedge clk); #1;
      exp_count += 2;
      checks++;
      if ({done, out_valid} !== 2'b10 || pkt_count !== exp_count) begin
         failures++;
         $display("FAIL b2b_done act=d%b v%b cnt%0d exp=d1 v0 cnt%0d", done, out_valid, pkt_count, exp_count);
      end
   endtask

   task automatic test_zero_len();
      @(negedge clk);
      start = 1'b1; pkt_len = 16'd0;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if ({len_err, out_valid, busy} !== 3'b100 || pkt_count !== exp_count) begin
         failures++;
         $display("FAIL zero_len_err act=e%b v%b b%b cnt%0d exp=e1 v0 b0 cnt%0d", len_err, out_valid, busy, pkt_count, exp_count);
      end
      @(negedge clk); #1;
      checks++;
      if ({len_err, out_valid} !== 2'b00) begin
         failures++; $display("FAIL zero_len_pulse act=e%b v%b exp=e0 v0", len_err, out_valid);
      end
      @(negedge clk);
      seed_load = 1'b1; seed = 32'h0; start = 1'b1; pkt_len = 16'd2;
      model = 32'hACE1_2345;
      @(negedge clk);
      seed_load = 1'b0; start = 1'b1; pkt_len = 16'd5;
      #1;
      checks++;
      if ({out_data, out_startofpacket} !== {8'h45, 1'b1}) begin
         failures++; $display("FAIL zero_seed_data act=%h s%b exp=45 s1", out_data, out_startofpacket);
      end
      model = lfsr_next(model);
      @(negedge clk);
      start = 1'b1; pkt_len = 16'd0;
      #1;
      checks++;
      if ({out_data, out_endofpacket} !== {model[7:0], 1'b1}) begin
         failures++;
         $display("FAIL zero_ignore_start act=%h e%b exp=%h e1", out_data, out_endofpacket, model[7:0]);
      end
      model = lfsr_next(model);
      @(negedge clk);
      start = 1'b0;
      #1;
      exp_count++;
      checks++;
      if ({len_err, done, out_valid} !== 3'b110 || pkt_count !== exp_count) begin
         failures++;
         $display("FAIL zero_eop_err act=e%b d%b v%b cnt%0d exp=e1 d1 v0 cnt%0d", len_err, done, out_valid, pkt_count, exp_count);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] m;
      m = 32'hDEAD_BEEF;
      @(negedge clk);
      seed_load = 1'b1; seed = 32'hDEAD_BEEF; start = 1'b1; pkt_len = 16'd20;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         seed_load = 1'b0; start = 1'b0;
         #1;
         checks++;
         if (out_data !== m[7:0]) begin
            failures++; $display("FAIL rmid_beat%0d act=%h exp=%h", i, out_data, m[7:0]);
         end
         m = lfsr_next(m);
      end
      @(negedge clk); #1;
      reset_n = 1'b0;
      #1;
      exp_count = 0;
      checks++;
      if ({out_valid, busy, out_endofpacket} !== 3'b000 || pkt_count !== 32'd0) begin
         failures++;
         $display("FAIL rmid_async act=v%b b%b e%b cnt%0d exp=v0 b0 e0 cnt0", out_valid, busy, out_endofpacket, pkt_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      seed_load = 1'b1; seed = 32'hDEAD_BEEF; start = 1'b1; pkt_len = 16'd20;
      @(negedge clk);
      seed_load = 1'b0; start = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data, out_startofpacket} !== {1'b1, 8'hEF, 1'b1}) begin
         failures++;
         $display("FAIL rmid_restart act=v%b d%h s%b exp=v1 dEF s1", out_valid, out_data, out_startofpacket);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_single();
      test_stall();
      test_back_to_back();
      test_zero_len();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
